// File: rtl/dma_cmd_sched.sv
// DMA command scheduler: round-robin arbitration between two descriptor
// requesters, APB programming of the DMA register port, interrupt wait with
// a watchdog, and per-requester done/err completion pulses.
module dma_cmd_sched #(
   parameter int TIMEOUT = 4096
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_src0,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_dst0,
   input  logic [31:0] req_dst1,
   input  logic [15:0] req_size0,
   input  logic [15:0] req_size1,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic        PREADY,
   input  logic        INTR,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_INTR, COMPLETE} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  regIdx_q, regIdx_d;
   logic [15:0] wdog_q, wdog_d;
   logic        timeout_q, timeout_d;
   logic        gnt_q, gnt_d;
   logic        lastGnt_q, lastGnt_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] size_q, size_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;

   logic [1:0]  grant;
   logic        sel;
   logic [31:0] selSrc;
   logic [31:0] selDst;
   logic [15:0] selSize;
   logic [2:0]  nextIdx;
   logic [31:0] nextData;

   // Pick a requester: on a tie the one not served last wins, otherwise the lone requester.
   always_comb begin
      sel     = 1'b0;
      selSrc  = req_src0;
      selDst  = req_dst0;
      selSize = req_size0;
      if (req_valid == 2'b11) begin
         sel = ~lastGnt_q;
      end else begin
         sel = req_valid[1];
      end
      if (sel) begin
         selSrc  = req_src1;
         selDst  = req_dst1;
         selSize = req_size1;
      end
   end

   // Address and data of the register write that follows the current one in the programming sequence.
   always_comb begin
      nextIdx  = regIdx_q + 3'd1;
      nextData = 32'h1;
      case (nextIdx)
         3'd1:    nextData = dst_q;
         3'd2:    nextData = {16'h0, size_q};
         default: nextData = 32'h1;
      endcase
   end

   // Next-state logic for the scheduler FSM and all its datapath registers.
   always_comb begin
      state_d   = state_q;
      regIdx_d  = regIdx_q;
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      gnt_d     = gnt_q;
      lastGnt_d = lastGnt_q;
      src_d     = src_q;
      dst_d     = dst_q;
      size_d    = size_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      done_d    = 2'b00;
      err_d     = 2'b00;
      grant     = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant[sel] = 1'b1;
               gnt_d      = sel;
               lastGnt_d  = sel;
               src_d      = selSrc;
               dst_d      = selDst;
               size_d     = selSize;
               regIdx_d   = 3'd0;
               if (selSize == 16'h0) begin
                  state_d = COMPLETE;
               end else begin
                  state_d  = SETUP;
                  paddr_d  = 32'h0;
                  pwdata_d = selSrc;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               case (regIdx_q)
                  3'd3: begin
                     state_d = WAIT_INTR;
                     wdog_d  = 16'h0;
                  end
                  3'd4: begin
                     state_d = COMPLETE;
                  end
                  default: begin
                     regIdx_d = nextIdx;
                     state_d  = SETUP;
                     paddr_d  = {27'h0, nextIdx, 2'b00};
                     pwdata_d = nextData;
                  end
               endcase
            end
         end
         WAIT_INTR: begin
            wdog_d = wdog_q + 16'd1;
            if (INTR || (wdog_q == TIMEOUT_LAST)) begin
               timeout_d = ~INTR;
               regIdx_d  = 3'd4;
               state_d   = SETUP;
               paddr_d   = 32'h10;
               pwdata_d  = 32'h1;
            end
         end
         COMPLETE: begin
            done_d[gnt_q] = 1'b1;
            err_d[gnt_q]  = timeout_q;
            timeout_d     = 1'b0;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         regIdx_q  <= 3'd0;
         wdog_q    <= 16'h0;
         timeout_q <= 1'b0;
         gnt_q     <= 1'b0;
         lastGnt_q <= 1'b1;
         src_q     <= 32'h0;
         dst_q     <= 32'h0;
         size_q    <= 16'h0;
         paddr_q   <= 32'h0;
         pwdata_q  <= 32'h0;
         done_q    <= 2'b00;
         err_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         regIdx_q  <= regIdx_d;
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
         gnt_q     <= gnt_d;
         lastGnt_q <= lastGnt_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         size_q    <= size_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // APB controls follow the state directly so reset idles the bus without waiting for a clock.
   always_comb begin
      PSEL      = (state_q == SETUP) || (state_q == ACCESS);
      PENABLE   = (state_q == ACCESS);
      PWRITE    = PSEL;
      PADDR     = paddr_q;
      PWDATA    = pwdata_q;
      busy      = (state_q != IDLE);
      done      = done_q;
      err       = err_q;
      req_ready = grant & {2{RSTN}};
   end

endmodule

// File: tb/tb_dma_cmd_sched.sv
// Self-checking bench for dma_cmd_sched: scoreboard of expected grants, APB
// writes and completion pulses, plus per-scenario timing checks.
module tb_dma_cmd_sched;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [31:0] req_src0 = 32'h0;
   logic [31:0] req_src1 = 32'h0;
   logic [31:0] req_dst0 = 32'h0;
   logic [31:0] req_dst1 = 32'h0;
   logic [15:0] req_size0 = 16'h0;
   logic [15:0] req_size1 = 16'h0;
   logic [1:0]  done;
   logic [1:0]  err;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PREADY = 1'b0;
   logic        INTR = 1'b0;
   logic        busy;

   dma_cmd_sched #(.TIMEOUT(16)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src0(req_src0), .req_src1(req_src1),
      .req_dst0(req_dst0), .req_dst1(req_dst1),
      .req_size0(req_size0), .req_size1(req_size1),
      .done(done), .err(err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .INTR(INTR), .busy(busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } apbWr_t;

   apbWr_t      expWr[$];
   logic [3:0]  expDone[$];
   int          expGrant[$];
   apbWr_t      wrE;
   logic [3:0]  doneE;
   int          grantE;

   int          vectors = 0;
   int          miscompares = 0;
   int          cycleNum = 0;
   logic [31:0] waitAddr = 32'hFFFF_FFFF;
   int          waitNum = 0;
   int          waitCnt = 0;
   logic [31:0] waitSizeExp = 32'h0;
   int          sizeAccCycles = 0;
   int          pselCount = 0;
   bit          intrEnable = 1'b1;
   int          intrDelay = 0;
   bit          intrArm = 1'b0;
   int          intrCnt = 0;
   int          modeCycle = 0;
   int          intSetupCycle = 0;
   int          readyCycle[2] = '{0, 0};
   int          doneCycle[2] = '{0, 0};
   bit          pend[2] = '{1'b0, 1'b0};

   // 10 ns clock.
   always #5 CLK = ~CLK;

   // Cycle counter used for latency checks.
   always @(posedge CLK) cycleNum++;

   // Accept monitor: every req_ready is checked against the predicted grant order.
   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            vectors++;
            if (expGrant.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL grant: got req%0d, expected no grant", i);
            end else begin
               grantE = expGrant.pop_front();
               if (grantE != i) begin
                  miscompares++;
                  $display("[TB] FAIL grant: got req%0d, expected req%0d", i, grantE);
               end
            end
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL readyWhileBusy: busy=%b, expected 0", busy);
            end
            readyCycle[i] = cycleNum;
            pend[i] = 1'b1;
         end
      end
   end

   // Requester model: drop valid after acceptance and scramble the descriptor to prove it was captured.
   always @(posedge CLK) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (pend[i]) begin
            req_valid[i] = 1'b0;
            pend[i] = 1'b0;
            if (i == 0) begin
               req_src0 = $urandom; req_dst0 = $urandom; req_size0 = 16'($urandom);
            end else begin
               req_src1 = $urandom; req_dst1 = $urandom; req_size1 = 16'($urandom);
            end
         end
      end
   end

   // Completion monitor: every done/err pulse is popped against the scoreboard.
   always @(negedge CLK) begin
      if ((done != 2'b00) || (err != 2'b00)) begin
         vectors++;
         if (expDone.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL donePulse: got done=%b err=%b, expected none", done, err);
         end else begin
            doneE = expDone.pop_front();
            if ({done, err} !== doneE) begin
               miscompares++;
               $display("[TB] FAIL donePulse: got done=%b err=%b, expected done=%b err=%b",
                        done, err, doneE[3:2], doneE[1:0]);
            end
         end
         for (int i = 0; i < 2; i++) if (done[i]) doneCycle[i] = cycleNum;
      end
   end

   // APB slave and interrupt model: programmable wait states, write scoreboard, INTR after MODE.
   always @(negedge CLK) begin
      if (!RSTN) begin
         PREADY = 1'b0;
         INTR = 1'b0;
         waitCnt = 0;
         intrArm = 1'b0;
      end else begin
         if (intrArm) begin
            if (intrCnt == 0) begin
               INTR = 1'b1;
               intrArm = 1'b0;
            end else begin
               intrCnt--;
            end
         end
         if (PSEL) pselCount++;
         if (PSEL && !PENABLE) begin
            waitCnt = 0;
            PREADY = 1'b0;
            if (PADDR == 32'h10) intSetupCycle = cycleNum;
         end else if (PSEL && PENABLE) begin
            if ((PADDR == 32'h8) && (PWDATA == waitSizeExp)) sizeAccCycles++;
            if ((PADDR == waitAddr) && (waitCnt < waitNum)) begin
               PREADY = 1'b0;
               waitCnt++;
            end else begin
               PREADY = 1'b1;
               vectors++;
               if (expWr.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL apbWrite: got addr=%h data=%h, expected no write", PADDR, PWDATA);
               end else begin
                  wrE = expWr.pop_front();
                  if ((PADDR !== wrE.addr) || (PWDATA !== wrE.data) || (PWRITE !== 1'b1)) begin
                     miscompares++;
                     $display("[TB] FAIL apbWrite: got addr=%h data=%h pwrite=%b, expected addr=%h data=%h pwrite=1",
                              PADDR, PWDATA, PWRITE, wrE.addr, wrE.data);
                  end
               end
               if (PADDR == 32'hC) begin
                  modeCycle = cycleNum;
                  if (intrEnable) begin
                     if (intrDelay == 0) begin
                        INTR = 1'b1;
                     end else begin
                        intrArm = 1'b1;
                        intrCnt = intrDelay - 1;
                     end
                  end
               end
               if (PADDR == 32'h10) INTR = 1'b0;
            end
         end else begin
            PREADY = 1'b0;
         end
      end
   end

   // Predict one transfer: grant order, APB writes (none for size 0) and completion pulse.
   task automatic pushExpected(input int id, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] size, input bit errExp);
      logic [1:0] m;
      m = (id == 0) ? 2'b01 : 2'b10;
      expGrant.push_back(id);
      if (size != 16'h0) begin
         expWr.push_back('{32'h0,  src});
         expWr.push_back('{32'h4,  dst});
         expWr.push_back('{32'h8,  {16'h0, size}});
         expWr.push_back('{32'hC,  32'h1});
         expWr.push_back('{32'h10, 32'h1});
      end
      expDone.push_back({m, errExp ? m : 2'b00});
   endtask

   // Present a descriptor on one requester just after a rising edge.
   task automatic applyStimulus(input int id, input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] size);
      @(posedge CLK);
      #1;
      if (id == 0) begin
         req_src0 = src; req_dst0 = dst; req_size0 = size;
      end else begin
         req_src1 = src; req_dst1 = dst; req_size1 = size;
      end
      req_valid[id] = 1'b1;
   endtask

   // Wait (bounded) until every presented request is served and the scoreboard is empty.
   task automatic drain(input string name, input int maxCycles);
      int n;
      n = 0;
      while (((req_valid != 2'b00) || busy || (expDone.size() != 0)) && (n < maxCycles)) begin
         @(negedge CLK);
         n++;
      end
      vectors++;
      if (n >= maxCycles) begin
         miscompares++;
         $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
      end
      vectors++;
      if (expWr.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s_missingWrites: %0d writes outstanding, required 0", name, expWr.size());
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      repeat (3) @(negedge CLK);
      vectors++;
      if ({PSEL, PENABLE, PWRITE, busy, req_ready, done, err} !== 10'b0) begin
         miscompares++;
         $display("[TB] FAIL resetCtrl: got %b, expected 0", {PSEL, PENABLE, PWRITE, busy, req_ready, done, err});
      end
      vectors++;
      if ({PADDR, PWDATA} !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL resetBus: got addr=%h data=%h, expected 0", PADDR, PWDATA);
      end
   endtask

   task automatic test_tie();
      pushExpected(0, 32'hA000_0000, 32'hB000_0000, 16'd4, 1'b0);
      pushExpected(1, 32'hA100_0000, 32'hB100_0000, 16'd8, 1'b0);
      req_src0 = 32'hA000_0000; req_dst0 = 32'hB000_0000; req_size0 = 16'd4;
      req_src1 = 32'hA100_0000; req_dst1 = 32'hB100_0000; req_size1 = 16'd8;
      req_valid = 2'b11;
      @(negedge CLK);
      vectors++;
      if (req_ready !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL readyInReset: got %b, expected 00", req_ready);
      end
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      drain("tieFirst", 200);
      pushExpected(0, 32'hA200_0000, 32'hB200_0000, 16'd12, 1'b0);
      applyStimulus(0, 32'hA200_0000, 32'hB200_0000, 16'd12);
      drain("tieSingle", 200);
      pushExpected(1, 32'hA300_0000, 32'hB300_0000, 16'd2, 1'b0);
      pushExpected(0, 32'hA400_0000, 32'hB400_0000, 16'd3, 1'b0);
      @(posedge CLK);
      #1;
      req_src0 = 32'hA400_0000; req_dst0 = 32'hB400_0000; req_size0 = 16'd3;
      req_src1 = 32'hA300_0000; req_dst1 = 32'hB300_0000; req_size1 = 16'd2;
      req_valid = 2'b11;
      drain("tieRepeat", 200);
   endtask

   task automatic test_single();
      intrDelay = 1;
      pushExpected(0, 32'h0010_0003, 32'h0000_0001, 16'd10, 1'b0);
      applyStimulus(0, 32'h0010_0003, 32'h0000_0001, 16'd10);
      drain("single", 200);
      intrDelay = 0;
   endtask

   task automatic test_wait_states();
      waitAddr = 32'h8;
      waitNum = 3;
      waitSizeExp = 32'd300;
      sizeAccCycles = 0;
      pushExpected(1, 32'hC000_1000, 32'hD000_2000, 16'd300, 1'b0);
      applyStimulus(1, 32'hC000_1000, 32'hD000_2000, 16'd300);
      drain("waitStates", 200);
      vectors++;
      if (sizeAccCycles != 4) begin
         miscompares++;
         $display("[TB] FAIL sizeHold: got %0d held access cycles, expected 4", sizeAccCycles);
      end
      waitAddr = 32'hFFFF_FFFF;
      waitNum = 0;
   endtask

   task automatic test_timeout();
      intrEnable = 1'b0;
      pushExpected(0, 32'h0000_5000, 32'h0000_6000, 16'd7, 1'b1);
      applyStimulus(0, 32'h0000_5000, 32'h0000_6000, 16'd7);
      drain("timeout", 200);
      vectors++;
      if (intSetupCycle - modeCycle != 17) begin
         miscompares++;
         $display("[TB] FAIL timeoutLatency: got %0d, expected 17", intSetupCycle - modeCycle);
      end
      intrEnable = 1'b1;
      intrDelay = 16;
      pushExpected(1, 32'h0000_7000, 32'h0000_8000, 16'd9, 1'b0);
      applyStimulus(1, 32'h0000_7000, 32'h0000_8000, 16'd9);
      drain("intrAtExpiry", 200);
      vectors++;
      if (intSetupCycle - modeCycle != 17) begin
         miscompares++;
         $display("[TB] FAIL expiryLatency: got %0d, expected 17", intSetupCycle - modeCycle);
      end
      intrDelay = 0;
   endtask

   task automatic test_size0();
      pselCount = 0;
      pushExpected(1, 32'hEEEE_0000, 32'hFFFF_0000, 16'd0, 1'b0);
      applyStimulus(1, 32'hEEEE_0000, 32'hFFFF_0000, 16'd0);
      drain("size0", 50);
      vectors++;
      if (pselCount != 0) begin
         miscompares++;
         $display("[TB] FAIL size0Psel: got %0d PSEL cycles, expected 0", pselCount);
      end
      vectors++;
      if (doneCycle[1] - readyCycle[1] != 2) begin
         miscompares++;
         $display("[TB] FAIL size0Latency: got %0d, expected 2", doneCycle[1] - readyCycle[1]);
      end
   endtask

   task automatic test_back_to_back();
      pushExpected(0, 32'h1111_0000, 32'h2222_0000, 16'd4, 1'b0);
      pushExpected(1, 32'h3333_0000, 32'h4444_0000, 16'd8, 1'b0);
      applyStimulus(0, 32'h1111_0000, 32'h2222_0000, 16'd4);
      repeat (2) @(posedge CLK);
      applyStimulus(1, 32'h3333_0000, 32'h4444_0000, 16'd8);
      drain("backToBack", 200);
      vectors++;
      if (doneCycle[0] - readyCycle[0] != 13) begin
         miscompares++;
         $display("[TB] FAIL b2bLatency0: got %0d, expected 13", doneCycle[0] - readyCycle[0]);
      end
      vectors++;
      if (readyCycle[1] != doneCycle[0]) begin
         miscompares++;
         $display("[TB] FAIL b2bRegrant: got cycle %0d, expected %0d", readyCycle[1], doneCycle[0]);
      end
      vectors++;
      if (doneCycle[1] - readyCycle[1] != 13) begin
         miscompares++;
         $display("[TB] FAIL b2bLatency1: got %0d, expected 13", doneCycle[1] - readyCycle[1]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      waitAddr = 32'h4;
      waitNum = 1000;
      pushExpected(0, 32'hAAAA_0000, 32'hBBBB_0000, 16'd64, 1'b0);
      applyStimulus(0, 32'hAAAA_0000, 32'hBBBB_0000, 16'd64);
      n = 0;
      while (!(PSEL && PENABLE && (PADDR == 32'h4)) && (n < 50)) begin
         @(negedge CLK);
         n++;
      end
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("[TB] FAIL dstAccess: not reached after %0d cycles, required ACCESS at 0x4", n);
      end
      repeat (2) @(negedge CLK);
      RSTN = 1'b0;
      #1;
      vectors++;
      if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0) begin
         miscompares++;
         $display("[TB] FAIL asyncAbort: got psel/penable/pwrite/busy=%b, expected 0000",
                  {PSEL, PENABLE, PWRITE, busy});
      end
      expWr.delete();
      expDone.delete();
      expGrant.delete();
      waitAddr = 32'hFFFF_FFFF;
      waitNum = 0;
      repeat (3) @(negedge CLK);
      vectors++;
      if ({PADDR, PWDATA} !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL midResetBus: got addr=%h data=%h, expected 0", PADDR, PWDATA);
      end
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      repeat (5) @(negedge CLK);
      pushExpected(0, 32'h1234_5678, 32'h9ABC_DEF0, 16'd33, 1'b0);
      applyStimulus(0, 32'h1234_5678, 32'h9ABC_DEF0, 16'd33);
      drain("afterReset", 200);
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_tie();
      test_single();
      test_wait_states();
      test_timeout();
      test_size0();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case a scenario never returns.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] global timeout");
   end

endmodule

// File: doc/dma_cmd_sched.md
DMA_CMD_SCHED -- requirements
Module: dma_cmd_sched

Interface
REQ-001 Parameter TIMEOUT, default 4096: maximum number of WAIT_INTR cycles before the watchdog aborts a transfer.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 req_valid[1:0]  input  2  per-requester descriptor valid.
REQ-005 req_ready[1:0]  output  2  per-requester one-cycle accept pulse.
REQ-006 req_src0/req_src1  input  32 each  source byte address.
REQ-007 req_dst0/req_dst1  input  32 each  destination byte address.
REQ-008 req_size0/req_size1  input  16 each  transfer size in bytes.
REQ-009 done[1:0]  output  2  per-requester one-cycle completion pulse.
REQ-010 err[1:0]  output  2  per-requester one-cycle timeout pulse, coincident with done.
REQ-011 PSEL, PENABLE, PWRITE  output  1 each  APB master controls toward the DMA register port.
REQ-012 PADDR  output  32  APB address.
REQ-013 PWDATA  output  32  APB write data.
REQ-014 PREADY  input  1  APB slave ready.
REQ-015 INTR  input  1  DMA completion interrupt.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, SETUP, ACCESS, WAIT_INTR and COMPLETE.
REQ-018 In IDLE with any req_valid high: grant one requester, capture its src/dst/size, pulse its req_ready for one cycle, set reg_idx=0 and go to SETUP.
REQ-019 Arbitration SHALL be round-robin: with both requests valid, grant the requester not granted last; a single valid requester is always granted.
REQ-020 After reset the last-grant pointer SHALL point to requester 1, so requester 0 wins the first tie.
REQ-021 A requester SHALL hold req_valid and its descriptor stable until it sees req_ready; the block ignores descriptor changes after capture.
REQ-022 Programming sequence by reg_idx 0..3: write 0x00=src, 0x04=dst, 0x08=zero-extended size, 0x0C=32'h1 (MODE start).
REQ-023 reg_idx 4 is the clear write: 0x10=32'h1 (INT clear).
REQ-024 SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid; next state ACCESS.
REQ-025 ACCESS: PSEL=1, PENABLE=1, PADDR/PWDATA held; remain in ACCESS while PREADY=0.
REQ-026 On PREADY=1 in ACCESS: reg_idx 0-2 increment and go to SETUP; reg_idx 3 goes to WAIT_INTR; reg_idx 4 goes to COMPLETE.
REQ-027 Outside SETUP and ACCESS: PSEL=PENABLE=PWRITE=0; PADDR and PWDATA hold their last values.
REQ-028 WAIT_INTR: increment a 16-bit watchdog from 0 each cycle. On INTR=1, set reg_idx=4 and go to SETUP. On watchdog reaching TIMEOUT-1 without INTR, set timeout flag, set reg_idx=4 and go to SETUP.
REQ-029 INTR and watchdog expiry in the same cycle SHALL count as success.
REQ-030 COMPLETE: pulse done[g] for the granted requester (and err[g] if timeout flag), clear the timeout flag, return to IDLE; a new grant is possible on the following cycle.
REQ-031 Size 0: after capture go directly to COMPLETE with no APB traffic; done pulses 2 cycles after req_ready.
REQ-032 Back-to-back minimum: a transfer with zero-wait PREADY and INTR present on WAIT_INTR entry takes 13 cycles from req_ready to done.
REQ-033 A new req_valid arriving while busy SHALL wait; it is never dropped and never receives req_ready before IDLE.

Reset
REQ-034 RSTN low: state=IDLE; PSEL, PENABLE, PWRITE, req_ready, done, err and busy = 0; PADDR, PWDATA, reg_idx, watchdog and captured descriptor = 0; last-grant pointer = 1.
REQ-035 RSTN asserted mid-transfer SHALL abort immediately with no done pulse; the APB bus returns idle asynchronously.

Verification
REQ-036 Single request: req0 src=0x0010_0003, dst=0x0000_0001, size=10, PREADY=1, INTR one cycle after the MODE write -> APB writes 0x0:0x00100003, 0x4:0x1, 0x8:0xA, 0xC:0x1, 0x10:0x1 in order; then done[0]=1 and err=0.
REQ-037 Tie arbitration: both valid out of reset -> req0 granted first and req1 second; a repeated tie -> req0 is granted again only after req1.
REQ-038 Wait states: PREADY low for 3 cycles on the SIZE access -> PADDR=0x8 and PWDATA held stable with PENABLE=1 for 4 cycles; the sequence resumes correctly.
REQ-039 Timeout: TIMEOUT=16 with INTR never asserted -> INT write issues 16 cycles after WAIT_INTR entry; done[g] and err[g] pulse together.
REQ-040 Size 0: req1 with size=0 -> no PSEL activity; done[1] pulses 2 cycles after req_ready[1].
REQ-041 Reset during ACCESS of the DST write -> PSEL=0 immediately and no done pulse; after release, req0 re-presented is granted and programs from 0x0.
